// File: rtl/switch_bank_pkg.sv
// Shared constants and helpers for the switch bank: synchroniser depth and
// the counter-width helper used to size each debounce counter.
package switch_pkg;

  // Depth of the metastability synchroniser in front of each debouncer.
  localparam int SYNC_STAGES = 2;

  // Number of bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/switch_bank_if.sv
// Bundle of the per-channel bank signals. The master side drives the raw
// inputs and controls; the slave side (the bank) returns debounced outputs
// and event pulses.
interface switch_bank_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] invert;
  logic [WIDTH-1:0] inp;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (
    output en, invert, inp,
    input  out, rise, fall
  );

  modport slave (
    input  en, invert, inp,
    output out, rise, fall
  );
endinterface

// File: rtl/switch_bank_channel.sv
// One switch channel: synchronise a raw asynchronous input, accept a new
// level only after it has been stable for DEBOUNCE enabled cycles, and emit
// one-cycle rise/fall pulses whenever the accepted level changes.
module switch_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic invert,
  input  logic inp,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int             CW       = clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s2;

  // The last synchroniser stage is the only safe view of the raw input.
  assign s2 = sync_q[SYNC_STAGES-1];

  // Next state: the synchroniser always shifts; the debouncer counts only
  // while enabled and resets its count whenever the input agrees with level.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], inp};
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      if (s2 == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = s2;
        cnt_d   = '0;
        rise_d  = s2;
        fall_d  = ~s2;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State register with synchronous active-low clear of every flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Output polarity is selectable without disturbing the debounced level.
  assign out  = level_q ^ invert;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/switch_bank.sv
// Bank of WIDTH independent debounced switch channels sharing one clock,
// reset and enable.
module switch_bank
  import switch_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  switch_bank_if.slave  bus
);

  logic [WIDTH-1:0] outVec;
  logic [WIDTH-1:0] riseVec;
  logic [WIDTH-1:0] fallVec;

  for (genvar g = 0; g < WIDTH; g++) begin : gChannel
    switch_channel #(
      .DEBOUNCE (DEBOUNCE)
    ) uChannel (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (bus.en),
      .invert (bus.invert[g]),
      .inp    (bus.inp[g]),
      .out    (outVec[g]),
      .rise   (riseVec[g]),
      .fall   (fallVec[g])
    );
  end

  assign bus.out  = outVec;
  assign bus.rise = riseVec;
  assign bus.fall = fallVec;

endmodule

// File: tb/tb_switch_bank.sv
// Bench for switch_bank: directed vector tables for a 4-channel DEBOUNCE=4
// bank and a 1-channel DEBOUNCE=1 bank, followed by randomised stimulus
// compared against a sliding-window reference model of the debounce rule.
module tb_switch_bank;

  typedef struct {
    logic       rstN;
    logic       en;
    logic [3:0] inv;
    logic [3:0] inp;
    logic [3:0] expOut;
    logic [3:0] expRise;
    logic [3:0] expFall;
  } vecT;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] inp;
  } histT;

  localparam int D        = 4;
  localparam int HIST_MAX = 4096;

  logic clk;
  logic rst_n;
  logic rst1_n;

  switch_bank_if #(.WIDTH(4)) bus ();
  switch_bank_if #(.WIDTH(1)) bus1 ();

  switch_bank #(.WIDTH(4), .DEBOUNCE(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  switch_bank #(.WIDTH(1), .DEBOUNCE(1)) dutOne (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1)
  );

  int vecCount  = 0;
  int missCount = 0;

  vecT mainVecs[$];
  vecT oneVecs[$];

  histT       hist[HIST_MAX];
  int         edgeN = 0;
  logic [3:0] mLevel = '0;
  logic [3:0] mRise  = '0;
  logic [3:0] mFall  = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronised input seen by the debouncer at edge t: the raw input two
  // edges earlier, or zero if a reset cleared the synchroniser since then.
  function automatic logic [3:0] s2At(input int t);
    if (t < 2) return 4'b0;
    if (hist[t-1].rst || hist[t-2].rst) return 4'b0;
    return hist[t-2].inp;
  endfunction

  // Reference model: a channel changes level at an edge exactly when the
  // last D edges were all enabled, reset-free, and saw the opposite level.
  always @(posedge clk) begin
    if (edgeN < HIST_MAX) begin
      hist[edgeN] = '{rst: !rst_n, en: bus.en, inp: bus.inp};
      mRise = '0;
      mFall = '0;
      if (!rst_n) begin
        mLevel = '0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          bit flip;
          flip = 1'b1;
          for (int j = 0; j < D; j++) begin
            int idx;
            idx = edgeN - j;
            if (idx < 0) flip = 1'b0;
            else if (hist[idx].rst || !hist[idx].en) flip = 1'b0;
            else if (s2At(idx)[c] == mLevel[c]) flip = 1'b0;
          end
          if (flip) begin
            mRise[c]  = ~mLevel[c];
            mFall[c]  = mLevel[c];
            mLevel[c] = ~mLevel[c];
          end
        end
      end
      edgeN++;
    end
  end

  function automatic void addVec(input bit toOne, input logic rstN,
                                 input logic en, input logic [3:0] inv,
                                 input logic [3:0] inp, input logic [3:0] expOut,
                                 input logic [3:0] expRise,
                                 input logic [3:0] expFall, input int reps);
    vecT v;
    v = '{rstN: rstN, en: en, inv: inv, inp: inp,
          expOut: expOut, expRise: expRise, expFall: expFall};
    for (int r = 0; r < reps; r++) begin
      if (toOne) oneVecs.push_back(v);
      else       mainVecs.push_back(v);
    end
  endfunction

  task automatic applyStimulus(input bit toOne, input vecT v);
    if (toOne) begin
      rst1_n      = v.rstN;
      bus1.en     = v.en;
      bus1.invert = v.inv[0];
      bus1.inp    = v.inp[0];
    end else begin
      rst_n      = v.rstN;
      bus.en     = v.en;
      bus.invert = v.inv;
      bus.inp    = v.inp;
    end
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [3:0] actOut, input logic [3:0] actRise,
                             input logic [3:0] actFall, input logic [3:0] expOut,
                             input logic [3:0] expRise, input logic [3:0] expFall);
    vecCount++;
    if (actOut !== expOut || actRise !== expRise || actFall !== expFall) begin
      missCount++;
      $display("[TB] FAIL %s #%0d: out/rise/fall got %b/%b/%b want %b/%b/%b",
               name, idx, actOut, actRise, actFall, expOut, expRise, expFall);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.invert  = 4'hF;
    bus.inp     = 4'h0;
    rst1_n      = 1'b0;
    bus1.en     = 1'b1;
    bus1.invert = 1'b0;
    bus1.inp    = 1'b0;

    // Reset, first debounced rise, mode toggle, glitch rejection, 4-cycle pulse.
    addVec(0, 0, 1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 2);
    addVec(0, 1, 1, 4'hF, 4'h1, 4'hF, 4'h0, 4'h0, 5);
    addVec(0, 1, 1, 4'hF, 4'h1, 4'hE, 4'h1, 4'h0, 1);
    addVec(0, 1, 1, 4'hF, 4'h1, 4'hE, 4'h0, 4'h0, 1);
    addVec(0, 1, 1, 4'hF, 4'h5, 4'hE, 4'h0, 4'h0, 5);
    addVec(0, 1, 1, 4'hF, 4'h5, 4'hA, 4'h4, 4'h0, 1);
    addVec(0, 1, 1, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 1);
    addVec(0, 1, 1, 4'hF, 4'h5, 4'hA, 4'h0, 4'h0, 1);
    addVec(0, 1, 1, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 1);
    addVec(0, 1, 1, 4'h0, 4'h7, 4'h5, 4'h0, 4'h0, 3);
    addVec(0, 1, 1, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 4);
    addVec(0, 1, 1, 4'h0, 4'h7, 4'h5, 4'h0, 4'h0, 4);
    addVec(0, 1, 1, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 1);
    addVec(0, 1, 1, 4'h0, 4'h5, 4'h7, 4'h2, 4'h0, 1);
    addVec(0, 1, 1, 4'h0, 4'h5, 4'h7, 4'h0, 4'h0, 3);
    addVec(0, 1, 1, 4'h0, 4'h5, 4'h5, 4'h0, 4'h2, 1);
    addVec(0, 1, 1, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 1);
    // Enable freeze, then all four channels rise together.
    addVec(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    addVec(0, 1, 0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 10);
    addVec(0, 1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 3);
    addVec(0, 1, 1, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 1);
    addVec(0, 1, 1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1);
    // Reset arriving with a change in flight on channel 2.
    addVec(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    addVec(0, 1, 1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4);
    addVec(0, 0, 1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 1);
    addVec(0, 1, 1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 5);
    addVec(0, 1, 1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 1);
    addVec(0, 1, 1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 1);

    // DEBOUNCE=1 channel: two-edge latency and single-cycle pulses accepted.
    addVec(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    addVec(1, 1, 1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 2);
    addVec(1, 1, 1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 1);
    addVec(1, 1, 1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1);
    addVec(1, 1, 1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1);
    addVec(1, 1, 1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1);
    addVec(1, 1, 1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
    addVec(1, 1, 1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 1);
    addVec(1, 1, 1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1);
    addVec(1, 1, 1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 2);
    addVec(1, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1);
    addVec(1, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    addVec(1, 1, 1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1);
    addVec(1, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    addVec(1, 1, 1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1);
    addVec(1, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1);
    addVec(1, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    addVec(1, 1, 1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1);

    for (int i = 0; i <= mainVecs.size(); i++) begin
      @(negedge clk);
      if (i > 0)
        checkOutput("main", i - 1, bus.out, bus.rise, bus.fall,
                    mainVecs[i-1].expOut, mainVecs[i-1].expRise,
                    mainVecs[i-1].expFall);
      if (i < mainVecs.size()) applyStimulus(0, mainVecs[i]);
    end

    for (int i = 0; i <= oneVecs.size(); i++) begin
      @(negedge clk);
      if (i > 0)
        checkOutput("deb1", i - 1, {3'b0, bus1.out}, {3'b0, bus1.rise},
                    {3'b0, bus1.fall}, oneVecs[i-1].expOut & 4'h1,
                    oneVecs[i-1].expRise & 4'h1, oneVecs[i-1].expFall & 4'h1);
      if (i < oneVecs.size()) applyStimulus(1, oneVecs[i]);
    end

    // Randomised traffic: mostly slow input changes so many get accepted,
    // with occasional glitches, enable drops, resets and mode changes.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (i > 0)
        checkOutput("model", i, bus.out, bus.rise, bus.fall,
                    mLevel ^ bus.invert, mRise, mFall);
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 7) == 0) bus.inp[c] = ~bus.inp[c];
      bus.en = ($urandom_range(0, 19) != 0);
      rst_n  = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 15) == 0) bus.invert = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    checkOutput("model", 800, bus.out, bus.rise, bus.fall,
                mLevel ^ bus.invert, mRise, mFall);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/switch_bank.md
# switch_bank

Parametrised, clocked successor to the single CMOS `switch`: a bank of `WIDTH` independent switch channels. Each channel synchronises its input, debounces it over `DEBOUNCE` cycles, and drives an output that is the debounced level, either inverted (classic CMOS switch behaviour) or passed through. Per-channel one-cycle `rise`/`fall` event pulses are also produced. The block sits between raw asynchronous inputs (buttons, pads, transistor-level models) and synchronous logic.

## Interface
- `WIDTH`, default 4: number of channels, ≥1.
- `DEBOUNCE`, default 4: consecutive stable cycles required before a change is accepted, ≥1.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, synchronous and active-low.
- `en`  input  1: global enable; low freezes debounce.
- `invert`  input  WIDTH: per-channel mode; 1 gives `out = ~level` (CMOS switch), 0 gives `out = level`.
- `inp`  input  WIDTH: raw asynchronous channel inputs.
- `out`  output  WIDTH: debounced output, `level ^ invert`; combinational from registered `level`.
- `rise`  output  WIDTH: one-cycle registered pulse when `level` goes 0→1.
- `fall`  output  WIDTH: one-cycle registered pulse when `level` goes 1→0.

## Operation
- Per channel: 2-flop synchroniser (`s1`, `s2`), debounced `level` register, counter `cnt` of width clog2(DEBOUNCE+1).
- Reset (`rst_n`=0 at edge): `s1`=`s2`=0, `level`=0, `cnt`=0, `rise`=`fall`=0. During and after reset, `out` = `invert`.
- Synchroniser always runs, including with `en`=0; it is only cleared by reset.
- With `en`=1, at each edge:
  - `s2 == level`: `cnt` ← 0, no event.
  - `s2 != level` and `cnt == DEBOUNCE-1`: `level` ← `s2`, `cnt` ← 0, pulse `rise` or `fall` per direction.
  - Otherwise: `cnt` ← `cnt`+1.
- With `en`=0: `cnt` ← 0, `level` holds, `rise`=`fall`=0. On re-enable, counting restarts from 0.
- `rise`/`fall` are high for exactly one cycle and are never both high on a channel. Events are based on `level`, so `invert` has no effect on them.
- Changing `invert` changes `out` in the same cycle. It does not touch `level` or `cnt` and generates no event.
- Channels are fully independent; simultaneous changes on all channels are each handled normally.
- No state machine beyond per-channel counter/level; no saturation issues, since `cnt` never exceeds DEBOUNCE-1.

## Timing
- `inp` change first sampled at edge k: `s2` updated at edge k+1; `level`/`out`/event update at edge k+1+DEBOUNCE if `inp` held stable.
- DEBOUNCE=1: `level` follows `s2` one edge later (total latency 2 edges).
- Pulse on `s2` shorter than DEBOUNCE cycles: rejected, `cnt` cleared, no event.
- Reset mid-count: next edge clears everything; no event emitted for an in-flight change.
- `rst_n` has priority over `en`.

## Structure
- Package `switch_pkg`: `SYNC_STAGES` = 2 constant and a `clog2` function for counter width.
- Sub-module `switch_channel` (one synchroniser + debounce + event logic, ports `clk`, `rst_n`, `en`, `invert`, `inp`, `out`, `rise`, `fall`). `switch_bank` instantiates it `WIDTH` times via generate.
- No supply ports (`vdd`/`gnd`); purely behavioural RTL.

## Test plan
- WIDTH=4, DEBOUNCE=4, `invert`=4'b1111, reset held 2 cycles: `out`=4'b1111, `rise`=`fall`=0. Then `inp`=4'b0001 held: `out`[0]=0 and `rise`[0] pulses exactly 1 cycle, 5 edges after first sample.
- Glitch: `inp`[1] high for 3 cycles then low: `out`[1] stays 1, no `rise`/`fall`; a 4-cycle pulse produces `rise` then, after release, `fall` 4+1 edges later.
- Mode: with `level`=4'b0101, toggle `invert` 4'b1111→4'b0000: `out` goes 4'b1010→4'b0101 same cycle, no events.
- Enable: `en`=0, `inp`=4'b1111 for 10 cycles: `out`, `level` unchanged, no events. `en`=1: all four `rise` pulse together 4 edges later.
- Reset mid-operation: `inp`[2] rises, `rst_n` low at count 2: `level`=0, `cnt`=0, no `rise`. After release, with `inp` still high, `rise`[2] occurs 2+DEBOUNCE edges after the reset release edge.
- DEBOUNCE=1, WIDTH=1: `inp` toggle yields `out` change 2 edges after first sample. A 1-cycle `s2` pulse is accepted (rise then fall).
